// File: rtl/queue_2x55.sv
// Two-entry, 55-bit FIFO built on a single ram_2x55 storage macro.
// Define QUEUE_2X55_FLOW_EN to let a beat bypass storage when the queue is empty.

module ram_2x55 (
    input  logic        W0_clk,
    input  logic        W0_en,
    input  logic        W0_addr,
    input  logic [54:0] W0_data,
    input  logic        R0_clk,
    input  logic        R0_en,
    input  logic        R0_addr,
    output logic [54:0] R0_data
);
    logic [54:0] mem [0:1];
    // The read is combinational, so the read clock is only carried for port compatibility.
    logic unused_r0_clk;

    assign unused_r0_clk = R0_clk;

    always_ff @(posedge W0_clk) begin
        if (W0_en) begin
            mem[W0_addr] <= W0_data;
        end
    end

    assign R0_data = R0_en ? mem[R0_addr] : '0;
endmodule

module queue_2x55 #(
    parameter int WIDTH = 55,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_enq_valid,
    input  logic [WIDTH-1:0] io_enq_bits,
    output logic             io_enq_ready,
    output logic             io_deq_valid,
    output logic [WIDTH-1:0] io_deq_bits,
    input  logic             io_deq_ready,
    output logic [1:0]       io_count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] enq_ptr;
    logic [PTR_W-1:0] deq_ptr;
    logic             maybe_full;
    logic             ptr_match;
    logic             empty;
    logic             full;
    logic             do_enq;
    logic             do_deq;
    logic [WIDTH-1:0] ram_rdata;

    assign ptr_match = (enq_ptr == deq_ptr);
    assign empty     = ptr_match & ~maybe_full;
    assign full      = ptr_match & maybe_full;

    assign io_enq_ready = ~full;
    assign io_count     = {full, enq_ptr ^ deq_ptr};

`ifdef QUEUE_2X55_FLOW_EN
    // An empty queue forwards the producer beat straight through; if it is
    // consumed in the same cycle nothing is stored and no state moves.
    assign io_deq_valid = ~empty | io_enq_valid;
    assign io_deq_bits  = empty ? io_enq_bits : ram_rdata;
    assign do_enq       = io_enq_ready & io_enq_valid & ~(empty & io_deq_ready);
    assign do_deq       = io_deq_ready & io_deq_valid & ~empty;
`else
    assign io_deq_valid = ~empty;
    assign io_deq_bits  = ram_rdata;
    assign do_enq       = io_enq_ready & io_enq_valid;
    assign do_deq       = io_deq_ready & io_deq_valid;
`endif

    ram_2x55 ram (
        .W0_clk  (clock),
        .W0_en   (do_enq),
        .W0_addr (enq_ptr),
        .W0_data (io_enq_bits),
        .R0_clk  (clock),
        .R0_en   (1'b1),
        .R0_addr (deq_ptr),
        .R0_data (ram_rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            enq_ptr    <= '0;
            deq_ptr    <= '0;
            maybe_full <= 1'b0;
        end else begin
            if (do_enq) begin
                enq_ptr <= enq_ptr + 1'b1;
            end
            if (do_deq) begin
                deq_ptr <= deq_ptr + 1'b1;
            end
            if (do_enq != do_deq) begin
                maybe_full <= do_enq;
            end
        end
    end
endmodule

// File: tb/tb_queue_2x55.sv
// Directed bench for queue_2x55: vector table plus reset, throughput and flow-through sequences.

module tb_queue_2x55;
    logic        clock;
    logic        reset;
    logic        io_enq_valid;
    logic [54:0] io_enq_bits;
    logic        io_enq_ready;
    logic        io_deq_valid;
    logic [54:0] io_deq_bits;
    logic        io_deq_ready;
    logic [1:0]  io_count;

    int tests;
    int fails;

    queue_2x55 dut (
        .clock        (clock),
        .reset        (reset),
        .io_enq_valid (io_enq_valid),
        .io_enq_bits  (io_enq_bits),
        .io_enq_ready (io_enq_ready),
        .io_deq_valid (io_deq_valid),
        .io_deq_bits  (io_deq_bits),
        .io_deq_ready (io_deq_ready),
        .io_count     (io_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        enq_valid;
        logic [54:0] enq_bits;
        logic        deq_ready;
        logic        exp_enq_ready;
        logic        exp_deq_valid;
        logic [54:0] exp_deq_bits;
        logic [1:0]  exp_count;
    } vec_t;

    vec_t vecs [21];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ev, input logic [54:0] eb, input logic dr);
        io_enq_valid = ev;
        io_enq_bits  = eb;
        io_deq_ready = dr;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    function automatic vec_t mk(input logic ev, input logic [54:0] eb, input logic dr,
                                input logic er, input logic dv, input logic [54:0] db,
                                input logic [1:0] cnt);
        vec_t v;
        v.enq_valid     = ev;
        v.enq_bits      = eb;
        v.deq_ready     = dr;
        v.exp_enq_ready = er;
        v.exp_deq_valid = dv;
        v.exp_deq_bits  = db;
        v.exp_count     = cnt;
        return v;
    endfunction

    initial begin
        logic       exp_dv;
        logic [54:0] exp_db;
        tests = 0;
        fails = 0;

        // Rows are checked just before the clock edge that consumes their inputs.
        vecs[0]  = mk(0, 55'h0, 0, 1, 0, 55'h0, 0);
        vecs[1]  = mk(1, 55'h1, 0, 1, 0, 55'h0, 0);
        vecs[2]  = mk(0, 55'h0, 0, 1, 1, 55'h1, 1);
        vecs[3]  = mk(0, 55'h0, 1, 1, 1, 55'h1, 1);
        vecs[4]  = mk(1, 55'hA, 0, 1, 0, 55'h0, 0);
        vecs[5]  = mk(1, 55'hB, 0, 1, 1, 55'hA, 1);
        vecs[6]  = mk(1, 55'hC, 0, 0, 1, 55'hA, 2);
        vecs[7]  = mk(0, 55'h0, 1, 0, 1, 55'hA, 2);
        vecs[8]  = mk(0, 55'h0, 1, 1, 1, 55'hB, 1);
        vecs[9]  = mk(0, 55'h0, 0, 1, 0, 55'h0, 0);
        vecs[10] = mk(1, 55'hD, 0, 1, 0, 55'h0, 0);
        vecs[11] = mk(1, 55'hE, 0, 1, 1, 55'hD, 1);
        vecs[12] = mk(1, 55'hF, 1, 0, 1, 55'hD, 2);
        vecs[13] = mk(1, 55'hF, 0, 1, 1, 55'hE, 1);
        vecs[14] = mk(0, 55'h0, 1, 0, 1, 55'hE, 2);
        vecs[15] = mk(0, 55'h0, 1, 1, 1, 55'hF, 1);
        vecs[16] = mk(0, 55'h0, 0, 1, 0, 55'h0, 0);
        vecs[17] = mk(1, 55'h10, 0, 1, 0, 55'h0, 0);
        vecs[18] = mk(1, 55'h11, 1, 1, 1, 55'h10, 1);
        vecs[19] = mk(0, 55'h0, 1, 1, 1, 55'h11, 1);
        vecs[20] = mk(0, 55'h0, 0, 1, 0, 55'h0, 0);

        reset = 1'b1;
        drive(0, 55'h0, 0);
        next_cycle();
        next_cycle();
        chk("reset_enq_ready", 64'(io_enq_ready), 64'd1);
        chk("reset_deq_valid", 64'(io_deq_valid), 64'd0);
        chk("reset_count",     64'(io_count),     64'd0);
        reset = 1'b0;

        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].enq_valid, vecs[i].enq_bits, vecs[i].deq_ready);
            exp_dv = vecs[i].exp_deq_valid;
            exp_db = vecs[i].exp_deq_bits;
`ifdef QUEUE_2X55_FLOW_EN
            if (vecs[i].exp_count == 2'd0 && vecs[i].enq_valid) begin
                exp_dv = 1'b1;
                exp_db = vecs[i].enq_bits;
            end
`endif
            @(negedge clock);
            chk($sformatf("vec%0d_enq_ready", i), 64'(io_enq_ready), 64'(vecs[i].exp_enq_ready));
            chk($sformatf("vec%0d_deq_valid", i), 64'(io_deq_valid), 64'(exp_dv));
            chk($sformatf("vec%0d_count", i),     64'(io_count),     64'(vecs[i].exp_count));
            if (exp_dv) begin
                chk($sformatf("vec%0d_deq_bits", i), 64'(io_deq_bits), 64'(exp_db));
            end
            next_cycle();
        end

        // One beat per cycle with occupancy held at one.
        drive(1, 55'd1000, 0);
        next_cycle();
        for (int i = 1; i < 100; i++) begin
            drive(1, 55'(1000 + i), 1);
            @(negedge clock);
            chk($sformatf("stream%0d_bits", i), 64'(io_deq_bits), 64'(1000 + i - 1));
            chk($sformatf("stream%0d_count", i), 64'(io_count), 64'd1);
            chk($sformatf("stream%0d_enq_ready", i), 64'(io_enq_ready), 64'd1);
            next_cycle();
        end
        drive(0, 55'h0, 1);
        @(negedge clock);
        chk("stream_last_bits", 64'(io_deq_bits), 64'd1099);
        next_cycle();
        drive(0, 55'h0, 0);
        @(negedge clock);
        chk("stream_drained_valid", 64'(io_deq_valid), 64'd0);
        chk("stream_drained_count", 64'(io_count), 64'd0);

        // Asynchronous reset with two entries held, away from any clock edge.
        next_cycle();
        drive(1, 55'h21, 0);
        next_cycle();
        drive(1, 55'h22, 0);
        next_cycle();
        drive(0, 55'h0, 0);
        @(negedge clock);
        chk("pre_reset_count", 64'(io_count), 64'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_deq_valid", 64'(io_deq_valid), 64'd0);
        chk("async_reset_count",     64'(io_count),     64'd0);
        chk("async_reset_enq_ready", 64'(io_enq_ready), 64'd1);
        next_cycle();
        reset = 1'b0;
        drive(1, 55'h33, 0);
        next_cycle();
        drive(0, 55'h0, 0);
        @(negedge clock);
        chk("post_reset_deq_valid", 64'(io_deq_valid), 64'd1);
        chk("post_reset_deq_bits",  64'(io_deq_bits),  64'h33);
        chk("post_reset_count",     64'(io_count),     64'd1);
        next_cycle();
        drive(0, 55'h0, 1);
        next_cycle();
        drive(0, 55'h0, 0);
        @(negedge clock);
        chk("flow_pre_count", 64'(io_count), 64'd0);
        next_cycle();

        // Empty queue offered a beat while the consumer is ready.
        drive(1, 55'h7FF, 1);
        @(negedge clock);
`ifdef QUEUE_2X55_FLOW_EN
        chk("flow_deq_valid", 64'(io_deq_valid), 64'd1);
        chk("flow_deq_bits",  64'(io_deq_bits),  64'h7FF);
        next_cycle();
        drive(0, 55'h0, 0);
        @(negedge clock);
        chk("flow_next_count", 64'(io_count), 64'd0);
`else
        chk("noflow_deq_valid", 64'(io_deq_valid), 64'd0);
        next_cycle();
        drive(0, 55'h0, 0);
        @(negedge clock);
        chk("noflow_next_count", 64'(io_count), 64'd1);
        chk("noflow_next_bits",  64'(io_deq_bits), 64'h7FF);
`endif
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/queue_2x55.md
QUEUE_2X55 -- requirements
Module: queue_2x55

Interface
REQ-001 Parameter WIDTH, 55, payload width; fixed, matches the ram_2x55 data port.
REQ-002 Parameter DEPTH, 2, entry count; fixed, pointers are 1 bit.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 io_enq_valid  input  1  producer offers io_enq_bits.
REQ-006 io_enq_bits  input  55  enqueue payload.
REQ-007 io_enq_ready  output  1  queue can accept a beat.
REQ-008 io_deq_valid  output  1  io_deq_bits holds valid head entry.
REQ-009 io_deq_bits  output  55  head-of-queue payload.
REQ-010 io_deq_ready  input  1  consumer accepts a beat.
REQ-011 io_count  output  2  current occupancy, 0..2.

Function
REQ-012 Storage SHALL be one ram_2x55 instance; write port: W0_clk=clock, W0_en=do_enq, W0_addr=enq_ptr, W0_data=io_enq_bits; read port: R0_clk=clock, R0_en=1, R0_addr=deq_ptr.
REQ-013 State SHALL be exactly: enq_ptr (1b), deq_ptr (1b), maybe_full (1b).
REQ-014 ptr_match=(enq_ptr==deq_ptr); empty=ptr_match & !maybe_full; full=ptr_match & maybe_full.
REQ-015 io_enq_ready SHALL equal !full; io_deq_valid SHALL equal !empty; both combinational, no dependency on the opposite valid/ready input.
REQ-016 do_enq=io_enq_ready & io_enq_valid; do_deq=io_deq_ready & io_deq_valid.
REQ-017 On do_enq, enq_ptr SHALL toggle (wrap 1->0); on do_deq, deq_ptr SHALL toggle.
REQ-018 When do_enq != do_deq, maybe_full SHALL load do_enq; otherwise it SHALL hold.
REQ-019 io_deq_bits SHALL be the RAM read data at deq_ptr (combinational read); when io_deq_valid=0 its value is don't-care.
REQ-020 Latency: a beat enqueued in cycle N SHALL appear on io_deq_bits with io_deq_valid=1 in cycle N+1 (non-flow build).
REQ-021 io_count SHALL equal {full, enq_ptr ^ deq_ptr}.
REQ-022 Simultaneous enq and deq when neither full nor empty: both pointers advance, maybe_full unchanged, count unchanged.
REQ-023 Full: io_enq_ready=0, an asserted io_enq_valid SHALL cause no write and no state change.
REQ-024 Empty: io_deq_valid=0, io_deq_ready SHALL cause no state change.
REQ-025 Ordering SHALL be strict FIFO; no beat dropped or duplicated.

Reset
REQ-026 reset assertion SHALL clear enq_ptr, deq_ptr, maybe_full immediately, independent of clock.
REQ-027 While reset is high: io_enq_ready=1, io_deq_valid=0, io_count=0.
REQ-028 RAM contents SHALL NOT be reset; entries in flight at reset are discarded.
REQ-029 First enqueue SHALL be accepted on the first rising clock edge after reset deassertion.

Configuration
REQ-030 Macro QUEUE_2X55_FLOW_EN SHALL select flow-through mode.
REQ-031 Defined: when empty, io_deq_valid SHALL equal io_enq_valid and io_deq_bits SHALL equal io_enq_bits; if io_deq_ready is also 1, do_enq SHALL be suppressed (no RAM write, no pointer or maybe_full change).
REQ-032 Undefined: REQ-015 to REQ-020 apply unchanged; no combinational enq-to-deq path exists.

Verification
REQ-033 Reset then enq 55'h1 at cycle 1, deq_ready=0 -> cycle 2: deq_valid=1, deq_bits=55'h1, count=1, enq_ready=1.
REQ-034 Enq 55'hA, 55'hB back-to-back, deq_ready=0 -> count=2, enq_ready=0; offered 55'hC is not written; drain yields A, B, then deq_valid=0.
REQ-035 Full queue, enq_valid=1 and deq_ready=1 same cycle -> cycle-end: deq of head only, count=1, enq_ready=1 next cycle; next enq accepted.
REQ-036 Continuous enq/deq, one beat per cycle, 100 incrementing values with count held at 1 -> output sequence identical, pointers wrap 50 times, no stall.
REQ-037 Count=2, assert reset mid-cycle (no clock edge) -> deq_valid=0, count=0, enq_ready=1 immediately.
REQ-038 QUEUE_2X55_FLOW_EN defined, empty, enq_valid=1 bits=55'h7FF, deq_ready=1 -> same cycle deq_valid=1, deq_bits=55'h7FF; next cycle count=0; undefined build: deq_valid=0 that cycle, count=1 next.
